// File: rtl/bcd_decoder_if.sv
// Request/result bundle for the BCD-to-binary converter.
// The master drives start/bcd; the slave (decoder) answers with ready/done/result.
interface bcd_decoder_if #(
    parameter int MaxDigits    = 8,
    parameter int DecimalWidth = 32
);
    logic                      start;
    logic [MaxDigits*4-1:0]    bcd;
    logic                      ready;
    logic                      done;
    logic [DecimalWidth-1:0]   decimal;
    logic                      invalid;

    modport master (output start, bcd, input ready, done, decimal, invalid);
    modport slave  (input start, bcd, output ready, done, decimal, invalid);
endinterface

// File: rtl/bcd_decoder.sv
// Serial packed-BCD to binary converter: one digit per cycle, MSD first.
// Result (and invalid flag) is registered on the edge that enters DONE and
// held until the next completed conversion.
module bcd_decoder #(
    parameter int MaxDigits    = 8,
    parameter int DecimalWidth = 32
) (
    input  logic          clk,
    input  logic          rst,
    bcd_decoder_if.slave  bus
);
    localparam int BcdW = MaxDigits * 4;
    localparam int CntW = (MaxDigits > 1) ? $clog2(MaxDigits) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [BcdW-1:0]         sreg;
    logic [DecimalWidth-1:0] acc, acc_nxt;
    logic [DecimalWidth-1:0] decimal_q;
    logic [CntW-1:0]         cnt;
    logic                    err, err_nxt, invalid_q;
    logic [3:0]              nib;

    // Digit step: acc*10 built from two shifts so no multiplier is inferred.
    always_comb begin
        nib     = sreg[BcdW-1 -: 4];
        acc_nxt = (acc << 3) + (acc << 1) + DecimalWidth'(nib);
        err_nxt = err | (nib > 4'd9);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; CONVERT runs until the digit counter has reached zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONVERT;
            CONVERT: if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        bus.ready   = (state == IDLE);
        bus.done    = (state == DONE);
        bus.decimal = decimal_q;
        bus.invalid = invalid_q;
    end

    // Datapath: capture on accept, consume one nibble per CONVERT cycle,
    // publish the result on the last digit so it is valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            decimal_q <= '0;
            invalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg <= bus.bcd;
                        acc  <= '0;
                        err  <= 1'b0;
                        cnt  <= CntW'(MaxDigits - 1);
                    end
                end
                CONVERT: begin
                    acc  <= acc_nxt;
                    err  <= err_nxt;
                    sreg <= sreg << 4;
                    if (cnt == '0) begin
                        decimal_q <= err_nxt ? '0 : acc_nxt;
                        invalid_q <= err_nxt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_decoder.sv
// Directed + randomized bench for bcd_decoder against a positional-weight model.
module tb_bcd_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bcd_decoder_if #(.MaxDigits(8), .DecimalWidth(32)) bus ();
    bcd_decoder_if #(.MaxDigits(1), .DecimalWidth(4))  bus1 ();

    bcd_decoder #(.MaxDigits(8), .DecimalWidth(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    bcd_decoder #(.MaxDigits(1), .DecimalWidth(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value = sum of digit * 10^position; any non-decimal nibble poisons the result.
    function automatic logic [32:0] model(input logic [31:0] b);
        longint v = 0;
        longint p = 1;
        logic   inv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int d;
            d = int'((b >> (4 * i)) & 32'hF);
            if (d > 9) inv = 1'b1;
            v += longint'(d) * p;
            p *= 10;
        end
        return {inv, inv ? 32'd0 : v[31:0]};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge one cycle after done.
    task automatic conv(input string tag, input logic [31:0] b);
        logic [32:0] exp;
        int guard;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_rdy"}, 64'(bus.ready), 64'd1);
        exp = model(b);
        bus.bcd   = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.bcd   = $urandom;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) begin
                @(negedge clk);
                bus.bcd = $urandom;
            end
            check({tag, "_done"}, 64'(bus.done), 64'(k == 9));
            check({tag, "_busy"}, 64'(bus.ready), 64'd0);
        end
        check({tag, "_dec"}, 64'(bus.decimal), 64'(exp[31:0]));
        check({tag, "_inv"}, 64'(bus.invalid), 64'(exp[32]));
        @(negedge clk);
        check({tag, "_hold"}, 64'(bus.decimal), 64'(exp[31:0]));
        check({tag, "_idle"}, 64'({bus.ready, bus.done}), 64'b10);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] last_exp;
        logic [32:0] e;
        logic [31:0] rb;
        int          ndone;
        int          last_done;

        bus.start  = 1'b0;
        bus.bcd    = '0;
        bus1.start = 1'b0;
        bus1.bcd   = '0;

        // Reset state while rst is held.
        #1;
        check("rst_state", 64'({bus.ready, bus.done, bus.invalid}), 64'b100);
        check("rst_dec", 64'(bus.decimal), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First start right after release must be taken.
        conv("c12345678", 32'h12345678);
        conv("c99999999", 32'h99999999);
        conv("c0", 32'h00000000);
        conv("cbad", 32'h000A0001);
        conv("c42", 32'h00000042);

        // Random legal digits, occasionally one non-decimal nibble.
        for (int t = 0; t < 6; t++) begin
            rb = '0;
            for (int i = 0; i < 8; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) rb[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
            conv("rand", rb);
        end

        // start held high, bcd scrambled every cycle: one result per 10 cycles.
        ndone     = 0;
        last_done = -1;
        last_exp  = bus.decimal;
        bus.start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) begin
                e = model(q.pop_front());
                check("bb_dec", 64'(bus.decimal), 64'(e[31:0]));
                check("bb_inv", 64'(bus.invalid), 64'(e[32]));
                if (last_done >= 0) check("bb_gap", 64'(c - last_done), 64'd10);
                last_done = c;
                last_exp  = e[31:0];
                ndone++;
            end else if (c > 0) begin
                check("bb_hold", 64'(bus.decimal), 64'(last_exp));
            end
            bus.bcd = $urandom;
            if (bus.ready === 1'b1) q.push_back(bus.bcd);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("bb_count", 64'(ndone), 64'd4);
        check("bb_pending", 64'(q.size()), 64'd0);

        // Abort mid-conversion with reset.
        @(negedge clk);
        conv("pre_rst", 32'h00000055);
        bus.bcd   = 32'h87654321;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_state", 64'({bus.ready, bus.done, bus.invalid}), 64'b100);
        check("abort_dec", 64'(bus.decimal), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_nodone", 64'(ndone), 64'd0);
        conv("c7", 32'h00000007);

        // Single-digit instance: done two cycles after start.
        bus1.bcd   = 4'h7;
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        check("d1_conv", 64'({bus1.ready, bus1.done}), 64'b00);
        @(negedge clk);
        check("d1_done", 64'({bus1.ready, bus1.done}), 64'b01);
        check("d1_dec", 64'({bus1.invalid, bus1.decimal}), 64'h07);
        @(negedge clk);
        bus1.bcd   = 4'hC;
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        @(negedge clk);
        check("d1_bad", 64'({bus1.done, bus1.invalid, bus1.decimal}), 64'h30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_decoder.md
BCD_DECODER -- requirements
Module: bcd_decoder

Interface
REQ-001 The module SHALL have parameter MaxDigits, default 8, giving the number of BCD digits accepted per conversion.
REQ-002 The module SHALL have parameter DecimalWidth, default 32, giving the binary result width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: conversion request, sampled only while ready=1.
REQ-006 The module SHALL have port bcd, input, MaxDigits*4 bits: packed BCD, most significant digit in the top nibble.
REQ-007 The module SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a completed conversion.
REQ-009 The module SHALL have port decimal, output, DecimalWidth bits: binary value of the last completed conversion.
REQ-010 The module SHALL have port invalid, output, 1 bit: high when the last completed conversion contained a nibble greater than 9.

Function
REQ-011 The module SHALL implement three states: IDLE, CONVERT and DONE.
REQ-012 IDLE: ready=1; on start=1, the module SHALL capture bcd into an internal shift register, clear the accumulator and error flag, load the digit counter with MaxDigits-1, and go to CONVERT.
REQ-013 CONVERT: each cycle SHALL consume the top nibble n of the shift register, set acc = acc*10 + n, and shift the register left by 4.
REQ-014 The multiply by 10 SHALL be formed as (acc<<3)+(acc<<1), with no multiplier instance.
REQ-015 CONVERT SHALL last exactly MaxDigits cycles; when the counter is 0, the next state SHALL be DONE.
REQ-016 Any nibble greater than 9 consumed in CONVERT SHALL set a sticky error flag for the current conversion.
REQ-017 DONE (one cycle): done=1, and decimal and invalid SHALL be updated at the same edge that enters DONE.
REQ-018 The next state after DONE SHALL be IDLE.
REQ-019 If the error flag is set at completion, decimal SHALL be 0 and invalid SHALL be 1; otherwise decimal SHALL equal acc and invalid SHALL be 0.
REQ-020 Latency: start sampled at edge N SHALL produce done high during the cycle after edge N+MaxDigits, i.e. MaxDigits+1 cycles from start.
REQ-021 ready SHALL be 0 in CONVERT and DONE.
REQ-022 start asserted while ready=0 SHALL be ignored, with no queuing.
REQ-023 A start asserted in the cycle after done (IDLE) SHALL be accepted, so the minimum period between starts is MaxDigits+2 cycles.
REQ-024 decimal and invalid SHALL hold their values between done pulses and SHALL be unaffected by bcd changes during a conversion.
REQ-025 Arithmetic SHALL be modulo 2^DecimalWidth; callers size DecimalWidth >= ceil(MaxDigits*log2(10)) (27 for 8 digits), and no overflow flag is provided.
REQ-026 MaxDigits=1 SHALL be supported: a one-cycle CONVERT, with done two cycles after start.

Reset
REQ-027 On rst=1, the module SHALL asynchronously force state=IDLE, ready=1, done=0, decimal=0, invalid=0, and clear the accumulator, counter and shift register.
REQ-028 rst asserted mid-conversion SHALL abort the conversion, with no done pulse generated then or after release.
REQ-029 The first start is accepted on the first rising edge after rst deasserts.

Verification
REQ-030 bcd=32'h12345678, start for 1 cycle -> ready low for 9 cycles, done pulse 9 cycles after start, decimal=12345678, invalid=0.
REQ-031 bcd=32'h99999999 -> decimal=99999999 (0x5F5E0FF), invalid=0; bcd=32'h00000000 -> decimal=0.
REQ-032 bcd=32'h000A0001 -> done pulse with invalid=1, decimal=0; a following conversion of 32'h00000042 -> decimal=42, invalid=0.
REQ-033 start held high continuously with bcd changing mid-conversion -> exactly one done per 10 cycles, each result matching the bcd captured at its accepting edge.
REQ-034 rst pulsed 4 cycles into a conversion of 32'h87654321 -> outputs return to reset values immediately and no done follows; a new start of 32'h00000007 -> decimal=7.
